// File: rtl/bslex_bus_ctrl.sv
// Registered bidirectional pad controller for a shared tristate bus.
// A direction FSM inserts a hi-Z turnaround after each drive burst and can limit burst length.
module bslex_bus_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2,
    parameter int MAX_DRV  = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] dout,
    input  logic             drv_req,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] din,
    output logic             din_vld,
    output logic             drv_ack,
    output logic             drv_tmo,
    output logic             busy
);

    localparam int DCW = $clog2(((MAX_DRV < 1) ? 1 : MAX_DRV) + 1);
    localparam int TCW = $clog2(((TURN_CYC < 1) ? 1 : TURN_CYC) + 1);

    localparam logic [DCW-1:0] DRV_LAST  = DCW'((MAX_DRV > 0) ? MAX_DRV - 1 : 0);
    localparam logic [TCW-1:0] TURN_LAST = TCW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam bit             HAS_TMO   = (MAX_DRV > 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dout_q;
    logic [DCW-1:0]   drv_cnt;
    logic [TCW-1:0]   turn_cnt;
    logic             lockout;
    logic             timeout;

    assign timeout = HAS_TMO && (drv_cnt == DRV_LAST);

    // Pad enable and data both come straight from flops, so DOUT never reaches PAD combinationally.
    assign pad     = (state == DRIVE) ? dout_q : {WIDTH{1'bz}};
    assign drv_ack = (state == DRIVE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state    <= IDLE;
            dout_q   <= '0;
            din      <= '0;
            din_vld  <= 1'b0;
            drv_tmo  <= 1'b0;
            drv_cnt  <= '0;
            turn_cnt <= '0;
            lockout  <= 1'b0;
        end else begin
            drv_tmo <= 1'b0;
            if (!drv_req) begin
                lockout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (drv_req && !lockout) begin
                        state   <= DRIVE;
                        dout_q  <= dout;
                        drv_cnt <= '0;
                        din_vld <= 1'b0;
                    end else begin
                        din     <= pad;
                        din_vld <= 1'b1;
                    end
                end
                DRIVE: begin
                    dout_q  <= dout;
                    din_vld <= 1'b0;
                    // A timed-out burst re-arms only after the requester drops its request.
                    if (timeout) begin
                        state    <= TURN;
                        turn_cnt <= '0;
                        drv_tmo  <= 1'b1;
                        if (drv_req) begin
                            lockout <= 1'b1;
                        end
                    end else if (!drv_req) begin
                        state    <= TURN;
                        turn_cnt <= '0;
                    end else if (drv_cnt != {DCW{1'b1}}) begin
                        drv_cnt <= drv_cnt + 1'b1;
                    end
                end
                TURN: begin
                    din_vld <= 1'b0;
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else if (turn_cnt != {TCW{1'b1}}) begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bslex_bus_ctrl.sv
// Scoreboard bench for bslex_bus_ctrl: a burst-level reference model predicts each cycle,
// and a separate monitor compares the DUT one step after every rising edge.
module tb_bslex_bus_ctrl;

    localparam int WIDTH    = 8;
    localparam int TURN_CYC = 2;
    localparam int MAX_DRV  = 4;

    typedef struct {
        bit         driving;
        logic [7:0] padVal;
        logic [7:0] din;
        bit         dinKnown;
        bit         dinVld;
        bit         tmo;
        bit         busy;
    } expect_t;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             drv_req = 1'b0;
    logic [WIDTH-1:0] dout = '0;
    wire  [WIDTH-1:0] pad;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             drv_ack;
    logic             drv_tmo;
    logic             busy;

    logic             extEn = 1'b0;
    logic [WIDTH-1:0] extData = '0;

    expect_t scoreboard[$];
    int vectorCount = 0;
    int failCount   = 0;

    // Reference model: burst-level bookkeeping rather than a state register.
    bit         mDriving   = 1'b0;
    int         mDriveLen  = 0;
    int         mTurnLeft  = 0;
    bit         mLocked    = 1'b0;
    logic [7:0] mData      = '0;
    logic [7:0] mDin       = '0;
    bit         mDinKnown  = 1'b0;
    bit         mDinVld    = 1'b0;
    bit         mTmo       = 1'b0;

    assign pad = extEn ? extData : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    bslex_bus_ctrl #(
        .WIDTH   (WIDTH),
        .TURN_CYC(TURN_CYC),
        .MAX_DRV (MAX_DRV)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
        .dout   (dout),
        .drv_req(drv_req),
        .pad    (pad),
        .din    (din),
        .din_vld(din_vld),
        .drv_ack(drv_ack),
        .drv_tmo(drv_tmo),
        .busy   (busy)
    );

    task automatic modelStep(input bit rstbV, input bit reqV, input logic [7:0] doutV,
                             input bit extOn, input logic [7:0] extV);
        if (!rstbV) begin
            mDriving  = 1'b0;
            mDriveLen = 0;
            mTurnLeft = 0;
            mLocked   = 1'b0;
            mData     = '0;
            mDin      = '0;
            mDinKnown = 1'b1;
            mDinVld   = 1'b0;
            mTmo      = 1'b0;
            return;
        end
        mTmo = 1'b0;
        if (mTurnLeft > 0) begin
            mTurnLeft = mTurnLeft - 1;
            mDinVld   = 1'b0;
            if (!reqV) mLocked = 1'b0;
        end else if (mDriving) begin
            mData   = doutV;
            mDinVld = 1'b0;
            if (MAX_DRV > 0 && mDriveLen == MAX_DRV) begin
                mDriving  = 1'b0;
                mTurnLeft = TURN_CYC;
                mTmo      = 1'b1;
                mLocked   = reqV;
            end else if (!reqV) begin
                mDriving  = 1'b0;
                mTurnLeft = TURN_CYC;
                mLocked   = 1'b0;
            end else begin
                mDriveLen = mDriveLen + 1;
            end
        end else begin
            if (reqV && !mLocked) begin
                mDriving  = 1'b1;
                mDriveLen = 1;
                mData     = doutV;
                mDinVld   = 1'b0;
            end else begin
                mDin      = extV;
                mDinKnown = extOn;
                mDinVld   = 1'b1;
                if (!reqV) mLocked = 1'b0;
            end
        end
    endtask

    // One clock of stimulus, driven at the falling edge; the prediction for the next rising edge is queued.
    task automatic applyStimulus(input bit rstbV, input bit reqV, input logic [7:0] doutV,
                                 input bit extWant, input logic [7:0] extV);
        bit extOk;
        expect_t e;
        @(negedge clk);
        extOk = extWant && rstbV && !mDriving && (mTurnLeft == 0) && !(reqV && !mLocked);
        rstb    = rstbV;
        drv_req = reqV;
        dout    = doutV;
        extEn   = extOk;
        extData = extV;
        modelStep(rstbV, reqV, doutV, extOk, extV);
        e.driving  = mDriving;
        e.padVal   = mData;
        e.din      = mDin;
        e.dinKnown = mDinKnown;
        e.dinVld   = mDinVld;
        e.tmo      = mTmo;
        e.busy     = mDriving || (mTurnLeft > 0);
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() != 0) begin
                e = scoreboard.pop_front();
                checkOutput("drv_ack", {7'd0, drv_ack}, {7'd0, e.driving});
                checkOutput("busy",    {7'd0, busy},    {7'd0, e.busy});
                checkOutput("drv_tmo", {7'd0, drv_tmo}, {7'd0, e.tmo});
                checkOutput("din_vld", {7'd0, din_vld}, {7'd0, e.dinVld});
                if (e.driving) checkOutput("pad", pad, e.padVal);
                if (e.dinKnown) checkOutput("din", din, e.din);
            end
        end
    end

    initial begin : stimulus
        bit req;
        // Reset held with request asserted, then the request wins on the first live edge.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        repeat (2) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'h5A);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'hC3);

        // Held request runs into the drive limit, stays locked out, then re-arms after one low cycle.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            applyStimulus($urandom_range(0, 59) != 0, req, 8'($urandom),
                          1'($urandom_range(0, 1)), 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        vectorCount++;
        if (scoreboard.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
